transaction_sequencer: RTL and testbench
========================================

Name: transaction_sequencer

Overview:
- Control-side initiator for the coin datapath: issues the load strobes, operand values and per-step process codes that the datapath consumes, and consumes its done_step acknowledge.
- Replaces hand-driven switch/key stimulus with a deterministic FSM.
- Sits between board I/O (switches, debounced go pulse) and the datapath. The datapath's result_out bus does not pass through this block.

Parameters:
- N_STEPS, 4, number of process steps per transaction; process codes issued are 1..N_STEPS, N_STEPS <= 7.
- TIMEOUT, 255, maximum cycles to wait for done_step within one step (used only with WATCHDOG_EN).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle start pulse (debounced and synchronised upstream).
- player_sel  in  1  initiating player (0/1).
- amount_sel  in  8  transfer amount.
- key_sel  in  8  player key.
- done_step  in  1  datapath acknowledge, one-cycle pulse per completed step.
- player_in  out  1  registered player operand to the datapath.
- input_amount  out  8  registered amount operand.
- input_key  out  8  registered key operand.
- load_player  out  1  one-cycle load strobe.
- load_amount  out  1  one-cycle load strobe.
- load_key  out  1  one-cycle load strobe.
- load_register  out  1  one-cycle strobe; datapath copies memory_values into its working register.
- process  out  3  current step code; 0 = no operation.
- busy  out  1  high from LD_PLAYER through the last STEP/GAP.
- done  out  1  high in DONE.
- error  out  1  high in ERROR (watchdog only).
- step_idx  out  3  index of the active or last-issued step, for display.

Behaviour:
- Reset, synchronous and active-high: state=IDLE and every output 0 at the next edge. This also applies mid-transaction; no strobe may remain asserted after the reset edge.
- States: IDLE, LD_PLAYER, LD_AMOUNT, LD_KEY, LD_REG, STEP, GAP, DONE, ERROR.
- IDLE/DONE/ERROR with go=1:
  - Capture player_sel, amount_sel and key_sel into the output registers.
  - Clear done, error and step_idx.
  - Next state is LD_PLAYER.
  - go=0: hold the current state.
- go in any other state is ignored. Operands are frozen for the whole transaction.
- Load phase:
  - LD_PLAYER, LD_AMOUNT, LD_KEY and LD_REG each last exactly 1 cycle and assert only their own strobe.
  - Order is fixed: player, amount, key, register.
  - The first strobe appears in the cycle after go is sampled.
- STEP:
  - Entry sets step_idx to k (1..N_STEPS); process=k is held every cycle until done_step=1 is sampled.
  - done_step sampled with k<N_STEPS: next state GAP.
  - done_step sampled with k=N_STEPS: next state DONE.
- GAP: exactly 1 cycle with process=0, then STEP with k+1. This guarantees the datapath sees a code change between steps.
- done_step in any state other than STEP is ignored. A done_step that arrives in the same cycle as entry into STEP counts for that step.
- Best-case latency from the go sample to done=1: 4 load cycles + N_STEPS step cycles + (N_STEPS-1) gap cycles; for N_STEPS=4 this is 11 cycles.
- DONE: done=1, busy=0, process=0; held until go or reset.
- step_idx saturates at N_STEPS and never wraps.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - An 8-bit+ cycle counter clears on each STEP entry and increments every STEP cycle without done_step.
  - When the counter reaches TIMEOUT, the next state is ERROR: error=1, busy=0, process=0; step_idx keeps the failing step.
  - If done_step arrives in the same cycle the counter reaches TIMEOUT, done_step wins.
- Undefined: no counter; STEP waits indefinitely; error is tied to 0.

Decomposition:
- Shared package holds:
  - state enum/localparams for all nine states;
  - PROC_NOP=3'd0;
  - operand widths AMOUNT_W=8 and KEY_W=8;
  - default TIMEOUT.
  The datapath uses the same process-code constants.
- One natural sub-module: step_watchdog (counter + compare), instantiated only under WATCHDOG_EN.

Test Plan:
- Reset mid-LD_AMOUNT -> at the next edge all strobes, process, busy and done are 0, state is IDLE; a following go restarts from LD_PLAYER.
- go with player_sel=1, amount_sel=8'h2A, key_sel=8'h5C -> operands appear the cycle after go. load_player, load_amount, load_key and load_register each pulse on consecutive cycles 1-4, then process=1.
- Datapath model acknowledges each step after 3 cycles, N_STEPS=4 -> process sequence is 1,1,1,0,2,2,2,0,3,3,3,0,4,4,4. done=1 on the next cycle; step_idx=4.
- Immediate acknowledge (done_step every STEP cycle) -> done asserts 11 cycles after the go sample. Stray done_step pulses in IDLE and GAP are ignored, and go pulses while busy are ignored.
- WATCHDOG_EN with TIMEOUT=16, no acknowledge on step 2 -> error=1 and step_idx=2 after 16 STEP cycles, busy=0. The next go clears error and restarts.
- WATCHDOG_EN, done_step coincides with the count reaching TIMEOUT -> transaction advances to GAP, error stays 0.

Source files
------------

// File: rtl/transaction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// transaction_sequencer_pkg
// Shared definitions for the transaction sequencer and the coin datapath:
//   - state_t        : the nine sequencer states
//   - PROC_NOP/PROC_W: process-code encoding (0 = no operation)
//   - AMOUNT_W/KEY_W : operand widths
//   - DEFAULT_TIMEOUT: default per-step watchdog limit (WATCHDOG_EN builds)
// -----------------------------------------------------------------------------
package transaction_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LD_PLAYER = 4'd1,
        S_LD_AMOUNT = 4'd2,
        S_LD_KEY    = 4'd3,
        S_LD_REG    = 4'd4,
        S_STEP      = 4'd5,
        S_GAP       = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    localparam int           PROC_W          = 3;
    localparam logic [2:0]   PROC_NOP        = 3'd0;
    localparam int           AMOUNT_W        = 8;
    localparam int           KEY_W           = 8;
    localparam int           DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/transaction_sequencer_step_watchdog.sv
// -----------------------------------------------------------------------------
// step_watchdog
// Counts consecutive STEP cycles that pass without a done_step acknowledge and
// flags a timeout on the TIMEOUT-th such cycle. Only instantiated when the
// WATCHDOG_EN macro is defined.
// Ports:
//   clock       in  system clock
//   reset       in  synchronous active-high reset
//   i_active    in  sequencer is in STEP (counter is held at 0 otherwise,
//                   so it is clear on every STEP entry)
//   i_done_step in  datapath acknowledge
//   o_timeout   out this STEP cycle is the TIMEOUT-th without acknowledge;
//                   the sequencer gives done_step priority over it
// -----------------------------------------------------------------------------
module step_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_active,
    input  logic i_done_step,
    output logic o_timeout
);

    // At least 8 bits, wider if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || !i_active) begin
            r_count <= '0;
        end else if (!i_done_step && (r_count != LAST_CNT)) begin
            // Saturates: the sequencer leaves STEP once the limit is hit.
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of earlier un-acknowledged cycles of this step,
    // so equality with TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign o_timeout = i_active && (r_count == LAST_CNT);

endmodule

// File: rtl/transaction_sequencer.sv
// -----------------------------------------------------------------------------
// transaction_sequencer
// Control-side initiator for the coin datapath. On a go pulse it captures the
// operands, issues the player/amount/key/register load strobes on consecutive
// cycles, then walks process codes 1..N_STEPS, waiting for done_step on each
// and inserting one NOP gap cycle between steps.
//
// Optional feature: define WATCHDOG_EN to bound each step to TIMEOUT cycles;
// a timeout ends the transaction in ERROR. Without it, STEP waits forever and
// error is tied low.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   go                one-cycle start pulse (honoured in IDLE/DONE/ERROR only)
//   player_sel        initiating player
//   amount_sel[7:0]   transfer amount
//   key_sel[7:0]      player key
//   done_step         datapath per-step acknowledge
//   player_in         registered player operand
//   input_amount[7:0] registered amount operand
//   input_key[7:0]    registered key operand
//   load_player/load_amount/load_key/load_register  one-cycle load strobes
//   process[2:0]      current step code, 0 = NOP
//   busy              transaction in progress (load phase through last step)
//   done              transaction completed
//   error             watchdog expired (WATCHDOG_EN only)
//   step_idx[2:0]     active or last-issued step
// -----------------------------------------------------------------------------
module transaction_sequencer
    import transaction_sequencer_pkg::*;
#(
    parameter int N_STEPS = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                player_sel,
    input  logic [AMOUNT_W-1:0] amount_sel,
    input  logic [KEY_W-1:0]    key_sel,
    input  logic                done_step,
    output logic                player_in,
    output logic [AMOUNT_W-1:0] input_amount,
    output logic [KEY_W-1:0]    input_key,
    output logic                load_player,
    output logic                load_amount,
    output logic                load_key,
    output logic                load_register,
    output logic [PROC_W-1:0]   process,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [2:0]          step_idx
);

    if (N_STEPS < 1 || N_STEPS > 7 || TIMEOUT < 1) begin : g_bad_params
        $error("transaction_sequencer: need 1 <= N_STEPS <= 7 and TIMEOUT >= 1");
    end

    localparam logic [2:0] LAST_STEP = 3'(N_STEPS);

    state_t              r_state,      r_state_next;
    logic                r_player,     r_player_next;
    logic [AMOUNT_W-1:0] r_amount,     r_amount_next;
    logic [KEY_W-1:0]    r_key,        r_key_next;
    logic [2:0]          r_step_idx,   r_step_idx_next;
    logic                w_timeout;

`ifdef WATCHDOG_EN
    logic w_step_active;
    assign w_step_active = (r_state == S_STEP);

    step_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_step_watchdog (
        .clock       (clock),
        .reset       (reset),
        .i_active    (w_step_active),
        .i_done_step (done_step),
        .o_timeout   (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State and operand registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_player   <= 1'b0;
            r_amount   <= '0;
            r_key      <= '0;
            r_step_idx <= 3'd0;
        end else begin
            r_state    <= r_state_next;
            r_player   <= r_player_next;
            r_amount   <= r_amount_next;
            r_key      <= r_key_next;
            r_step_idx <= r_step_idx_next;
        end
    end

    // Next-state logic.
    always_comb begin
        r_state_next    = r_state;
        r_player_next   = r_player;
        r_amount_next   = r_amount;
        r_key_next      = r_key;
        r_step_idx_next = r_step_idx;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    // Operands are captured once here and stay frozen
                    // for the whole transaction.
                    r_player_next   = player_sel;
                    r_amount_next   = amount_sel;
                    r_key_next      = key_sel;
                    r_step_idx_next = 3'd0;
                    r_state_next    = S_LD_PLAYER;
                end
            end
            S_LD_PLAYER: r_state_next = S_LD_AMOUNT;
            S_LD_AMOUNT: r_state_next = S_LD_KEY;
            S_LD_KEY:    r_state_next = S_LD_REG;
            S_LD_REG: begin
                r_step_idx_next = 3'd1;
                r_state_next    = S_STEP;
            end
            S_STEP: begin
                // done_step outranks a coincident watchdog expiry.
                if (done_step) begin
                    r_state_next = (r_step_idx >= LAST_STEP) ? S_DONE : S_GAP;
                end else if (w_timeout) begin
                    r_state_next = S_ERROR;
                end
            end
            S_GAP: begin
                if (r_step_idx < LAST_STEP) begin
                    r_step_idx_next = r_step_idx + 3'd1;
                end
                r_state_next = S_STEP;
            end
            default: r_state_next = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, so reset clears them all
    // at the same edge that forces IDLE.
    assign player_in     = r_player;
    assign input_amount  = r_amount;
    assign input_key     = r_key;
    assign load_player   = (r_state == S_LD_PLAYER);
    assign load_amount   = (r_state == S_LD_AMOUNT);
    assign load_key      = (r_state == S_LD_KEY);
    assign load_register = (r_state == S_LD_REG);
    assign process       = (r_state == S_STEP) ? r_step_idx : PROC_NOP;
    assign busy          = (r_state == S_LD_PLAYER) || (r_state == S_LD_AMOUNT) ||
                           (r_state == S_LD_KEY)    || (r_state == S_LD_REG)    ||
                           (r_state == S_STEP)      || (r_state == S_GAP);
    assign done          = (r_state == S_DONE);
`ifdef WATCHDOG_EN
    assign error         = (r_state == S_ERROR);
`else
    assign error         = 1'b0;
`endif
    assign step_idx      = r_step_idx;

endmodule

// File: tb/tb_transaction_sequencer.sv
module tb_transaction_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic       player_sel;
    logic [7:0] amount_sel;
    logic [7:0] key_sel;
    logic       done_step;
    logic       player_in;
    logic [7:0] input_amount;
    logic [7:0] input_key;
    logic       load_player;
    logic       load_amount;
    logic       load_key;
    logic       load_register;
    logic [2:0] process;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] step_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    transaction_sequencer #(
        .N_STEPS (4),
        .TIMEOUT (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .go            (go),
        .player_sel    (player_sel),
        .amount_sel    (amount_sel),
        .key_sel       (key_sel),
        .done_step     (done_step),
        .player_in     (player_in),
        .input_amount  (input_amount),
        .input_key     (input_key),
        .load_player   (load_player),
        .load_amount   (load_amount),
        .load_key      (load_key),
        .load_register (load_register),
        .process       (process),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .step_idx      (step_idx)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic [3:0] exp);
        check({tag, ".strobes"}, {load_player, load_amount, load_key, load_register}, exp);
    endtask

    int exp_seq [15] = '{1, 1, 1, 0, 2, 2, 2, 0, 3, 3, 3, 0, 4, 4, 4};

    initial begin
        int cycles;
        int cnt2;
        int guard;
        logic ack2_seen;
        logic saw_err;

        reset = 1'b1; go = 1'b0; player_sel = 1'b0;
        amount_sel = 8'h00; key_sel = 8'h00; done_step = 1'b0;
        tick();
        tick();

        // ---- reset state
        check_strobes("rst", 4'b0000);
        check("rst.process", process, 0);
        check("rst.busy_done_err", {busy, done, error}, 0);
        check("rst.operands", {player_in, input_amount, input_key}, 0);
        check("rst.step_idx", step_idx, 0);
        reset = 1'b0;

        // ---- reset in the middle of LD_AMOUNT
        go = 1'b1; player_sel = 1'b1; amount_sel = 8'h11; key_sel = 8'h22;
        tick();
        go = 1'b0;
        check_strobes("mid.ld_player", 4'b1000);
        tick();
        check_strobes("mid.ld_amount", 4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_strobes("mid.after_rst", 4'b0000);
        check("mid.after_rst.proc_busy_done", {process, busy, done}, 0);
        check("mid.after_rst.operands", {player_in, input_amount, input_key}, 0);

        // stray done_step in IDLE
        done_step = 1'b1;
        tick();
        done_step = 1'b0;
        check("idle_stray.busy", busy, 0);
        check_strobes("idle_stray", 4'b0000);

        // ---- full transaction, 3-cycle acknowledge
        player_sel = 1'b1; amount_sel = 8'h2A; key_sel = 8'h5C; go = 1'b1;
        tick();
        go = 1'b0;
        check("tx.operands", {player_in, input_amount, input_key}, {1'b1, 8'h2A, 8'h5C});
        check_strobes("tx.c1", 4'b1000);
        check("tx.c1.busy", busy, 1);
        player_sel = 1'b0; amount_sel = 8'hFF; key_sel = 8'h00;
        tick();
        check_strobes("tx.c2", 4'b0100);
        tick();
        check_strobes("tx.c3", 4'b0010);
        tick();
        check_strobes("tx.c4", 4'b0001);
        check("tx.c4.process", process, 0);
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("tx.seq%0d.process", i), process, exp_seq[i]);
            check($sformatf("tx.seq%0d.step_idx", i), step_idx, (i / 4) + 1);
            check($sformatf("tx.seq%0d.busy_done", i), {busy, done}, 2'b10);
            done_step = ((i % 4) == 2);
            tick();
        end
        done_step = 1'b0;
        check("tx.done", done, 1);
        check("tx.end.busy_proc", {busy, process}, 0);
        check("tx.end.step_idx", step_idx, 4);
        check("tx.end.operands", {player_in, input_amount, input_key}, {1'b1, 8'h2A, 8'h5C});
        check("tx.end.error", error, 0);

        // ---- immediate acknowledge, stray done_step and go while busy
        done_step = 1'b1;
        tick();
        check("imm.done_hold", done, 1);
        player_sel = 1'b0; amount_sel = 8'h03; key_sel = 8'h04;
        go = 1'b1;
        tick();
        check("imm.restart.done", done, 0);
        check("imm.restart.step_idx", step_idx, 0);
        check("imm.restart.operands", {player_in, input_amount, input_key}, {1'b0, 8'h03, 8'h04});
        cycles = 0;
        while (!done && cycles < 30) begin
            cycles++;
            go = (cycles == 2) || (cycles == 6);
            tick();
        end
        go = 1'b0;
        done_step = 1'b0;
        check("imm.latency", cycles, 11);
        check("imm.done", done, 1);
        check("imm.step_idx", step_idx, 4);
        check("imm.operands", {player_in, input_amount, input_key}, {1'b0, 8'h03, 8'h04});

`ifdef WATCHDOG_EN
        // ---- no acknowledge on step 2 -> ERROR after 16 STEP cycles
        go = 1'b1;
        tick();
        go = 1'b0;
        cnt2 = 0; guard = 0;
        while (!error && guard < 100) begin
            if (process == 3'd2) cnt2++;
            done_step = (process == 3'd1);
            tick();
            guard++;
        end
        done_step = 1'b0;
        check("wd.error", error, 1);
        check("wd.step2_cycles", cnt2, 16);
        check("wd.step_idx", step_idx, 2);
        check("wd.busy_proc_done", {busy, process, done}, 0);
        tick();
        check("wd.error_hold", error, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("wd.restart.error", error, 0);
        check_strobes("wd.restart", 4'b1000);
        check("wd.restart.step_idx", step_idx, 0);

        // ---- done_step on the same cycle the limit is reached
        cnt2 = 0; guard = 0; ack2_seen = 1'b0; saw_err = 1'b0;
        while (!done && !error && guard < 200) begin
            if (ack2_seen) begin
                check("wdc.gap.process", process, 0);
                check("wdc.gap.busy", busy, 1);
                ack2_seen = 1'b0;
            end
            if (process == 3'd2) cnt2++;
            done_step = (process == 3'd1) || (process == 3'd3) || (process == 3'd4) ||
                        ((process == 3'd2) && (cnt2 == 16));
            if ((process == 3'd2) && (cnt2 == 16)) ack2_seen = 1'b1;
            tick();
            if (error) saw_err = 1'b1;
            guard++;
        end
        done_step = 1'b0;
        check("wdc.error", saw_err, 0);
        check("wdc.step2_cycles", cnt2, 16);
        check("wdc.done", done, 1);
        check("wdc.step_idx", step_idx, 4);
`else
        // ---- without watchdog STEP waits indefinitely
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 40; i++) tick();
        check("nowd.process", process, 1);
        check("nowd.busy", busy, 1);
        check("nowd.error", error, 0);
        check("nowd.step_idx", step_idx, 1);
        done_step = 1'b1;
        guard = 0;
        while (!done && guard < 20) begin
            tick();
            guard++;
        end
        done_step = 1'b0;
        check("nowd.done", done, 1);
        check("nowd.end.error", error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
